// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: opcode set, FSM states,
// and the reserved-opcode constant.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ASR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ROR  = 3'd6
    } usr_mode_e;

    localparam logic [2:0] MODE_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } usr_state_e;

endpackage

// File: rtl/dff_sync.sv
// Single storage bit with load enable and synchronous active-low reset.
module dff_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic en,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Multi-step universal shift register: LOAD/SHL/SHR/ASR (+ROL/ROR when
// USR_ROTATE_EN is defined), one bit per RUN cycle, with busy/done handshake.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] din_par,
    input  logic             din_ser,
    output logic [WIDTH-1:0] q,
    output logic             dout_msb,
    output logic             dout_lsb,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_reg, state_next;
    logic [2:0]       mode_reg, mode_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_next;
    logic             q_en;

    // Opcodes that walk through RUN; rotates only exist when the feature is built.
    function automatic logic is_shift(input logic [2:0] m);
        logic r;
        r = (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASR);
`ifdef USR_ROTATE_EN
        r = r || (m == MODE_ROL) || (m == MODE_ROR);
`endif
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic [2:0]       m,
                                              input logic             ds);
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            MODE_SHL: r = {v[WIDTH-2:0], ds};
            MODE_SHR: r = {ds, v[WIDTH-1:1]};
            MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR: r = {v[0], v[WIDTH-1:1]};
`endif
            default:  r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        q_next     = q;
        q_en       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    mode_next = mode;
                    cnt_next  = count;
                    if (mode == MODE_LOAD) begin
                        q_next     = din_par;
                        q_en       = 1'b1;
                        state_next = ST_DONE;
                    end else if (is_shift(mode) && (count != '0)) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                q_next   = step(q, mode_reg, din_ser);
                q_en     = 1'b1;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_HOLD;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff_sync u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (q_next[gi]),
                .en    (q_en),
                .q     (q[gi])
            );
        end
    endgenerate

    assign dout_msb = q[WIDTH-1];
    assign dout_lsb = q[0];
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8) with a cycle-countdown
// reference model; honours USR_ROTATE_EN when it is defined for the build.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [3:0] count = 4'd0;
    logic [7:0] din_par = 8'd0;
    logic       din_ser = 1'b0;
    logic [7:0] q;
    logic       dout_msb, dout_lsb, busy, done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model: expected register value and number of cycles still to be busy.
    logic [7:0] m_q = 8'd0;
    int         m_left = 0;
    int         m_mode = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .count    (count),
        .din_par  (din_par),
        .din_ser  (din_ser),
        .q        (q),
        .dout_msb (dout_msb),
        .dout_lsb (dout_lsb),
        .busy     (busy),
        .done     (done)
    );

    function automatic bit m_is_shift(input int md);
`ifdef USR_ROTATE_EN
        return (md >= 2) && (md <= 6);
`else
        return (md >= 2) && (md <= 4);
`endif
    endfunction

    function automatic logic [7:0] m_step(input logic [7:0] v, input int md, input logic ds);
        logic signed [7:0] sv;
        sv = v;
        case (md)
            2: return (v << 1) | {7'd0, ds};
            3: return (v >> 1) | (ds ? 8'h80 : 8'h00);
            4: return sv >>> 1;
            5: return (v << 1) | (v >> 7);
            6: return (v >> 1) | (v << 7);
            default: return v;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h expected=%02h", name, got, exp);
        end
    endtask

    // Apply one clock edge with the given inputs and advance the model.
    task automatic edge_in(input logic r, input logic s, input logic [2:0] m,
                           input logic [3:0] c, input logic [7:0] p, input logic ds);
        rst_n = r; start = s; mode = m; count = c; din_par = p; din_ser = ds;
        @(posedge clk);
        if (!r) begin
            m_q = 8'd0;
            m_left = 0;
        end else if (m_left == 0) begin
            if (s) begin
                m_mode = int'(m);
                if (m == 3'd1) begin
                    m_q = p;
                    m_left = 1;
                end else if (m_is_shift(int'(m)) && c != 4'd0) begin
                    m_left = int'(c) + 1;
                end else begin
                    m_left = 1;
                end
            end
        end else begin
            if (m_left > 1) m_q = m_step(m_q, m_mode, ds);
            m_left--;
        end
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic go(input logic [2:0] m, input logic [3:0] c, input logic [7:0] p);
        edge_in(1'b1, 1'b1, m, c, p, 1'b0);
        $display("txn mode=%0d count=%0d din_par=%02h -> q=%02h busy=%0b done=%0b",
                 m, c, p, q, busy, done);
    endtask

    task automatic shift_steps(input int n, input logic ds);
        for (int i = 0; i < n; i++) edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, ds);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_q", q, m_q);
            chk("cyc_msb", {7'd0, dout_msb}, {7'd0, m_q[7]});
            chk("cyc_lsb", {7'd0, dout_lsb}, {7'd0, m_q[0]});
            chk("cyc_busy", {7'd0, busy}, {7'd0, m_left > 0});
            chk("cyc_done", {7'd0, done}, {7'd0, m_left == 1});
        end
    end

    initial begin
        edge_in(1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
        edge_in(1'b0, 1'b1, 3'd1, 4'd0, 8'h77, 1'b0);
        chk_en = 1'b1;
        chk("reset_q", q, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        idle(1);

        // LOAD 0xA5: one busy cycle with done
        go(3'd1, 4'd0, 8'hA5);
        chk("load_q", q, 8'hA5);
        chk("load_done", {7'd0, done}, 8'h01);
        idle(1);
        chk("load_busy_end", {7'd0, busy}, 8'h00);

        // ASR 0x81 by 3 -> 0xF0, then SHR by 2 with zeros -> 0x3C
        go(3'd1, 4'd0, 8'h81); idle(1);
        go(3'd4, 4'd3, 8'h00);
        shift_steps(2, 1'b0);
        chk("asr_not_done", {7'd0, done}, 8'h00);
        shift_steps(1, 1'b0);
        chk("asr_q", q, 8'hF0);
        chk("asr_done", {7'd0, done}, 8'h01);
        idle(1);
        go(3'd3, 4'd2, 8'h00);
        shift_steps(2, 1'b0);
        chk("shr_q", q, 8'h3C);
        idle(1);

        // SHL 0x01 by 4 with serial 1,0,1,1 -> 0x1B
        go(3'd1, 4'd0, 8'h01); idle(1);
        go(3'd2, 4'd4, 8'h00);
        edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
        edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
        edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
        edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
        chk("shl_q", q, 8'h1B);
        chk("shl_msb", {7'd0, dout_msb}, 8'h00);
        chk("shl_lsb", {7'd0, dout_lsb}, 8'h01);
        idle(1);

        // ROL 0x96 by 11
        go(3'd1, 4'd0, 8'h96); idle(1);
        go(3'd5, 4'd11, 8'h00);
`ifdef USR_ROTATE_EN
        shift_steps(11, 1'b0);
        chk("rol_q", q, 8'hB4);
`else
        chk("rol_off_q", q, 8'h96);
        chk("rol_off_done", {7'd0, done}, 8'h01);
`endif
        idle(1);

        // HOLD, reserved opcode, and count=0 shift: immediate done, q kept
        go(3'd0, 4'd5, 8'hFF); idle(1);
        go(3'd7, 4'd5, 8'hFF); idle(1);
        go(3'd2, 4'd0, 8'hFF);
        chk("cnt0_done", {7'd0, done}, 8'h01);
        idle(1);

        // start during RUN is ignored: 0x10 SHL 3 with ones -> 0x87
        go(3'd1, 4'd0, 8'h10); idle(1);
        go(3'd2, 4'd3, 8'h00);
        edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
        edge_in(1'b1, 1'b1, 3'd1, 4'd0, 8'hFF, 1'b1);
        edge_in(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
        chk("ign_q", q, 8'h87);
        idle(3);

        // SHR count beyond WIDTH executed literally
        go(3'd3, 4'd9, 8'h00);
        shift_steps(9, 1'b1);
        chk("shr9_q", q, 8'hFF);
        idle(1);

        // Reset mid-RUN of SHL 6 on 0xFF, with a same-cycle start
        go(3'd1, 4'd0, 8'hFF); idle(1);
        go(3'd2, 4'd6, 8'h00);
        shift_steps(2, 1'b0);
        chk("pre_rst_q", q, 8'hFC);
        edge_in(1'b0, 1'b1, 3'd1, 4'd0, 8'h55, 1'b0);
        chk("rst_q", q, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        idle(8);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (>=2).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, shift-count width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port mode  input  3  opcode: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR, 7 reserved.
REQ-007 SHALL have port count  input  CNT_W  number of single-bit steps.
REQ-008 SHALL have port din_par  input  WIDTH  parallel load data.
REQ-009 SHALL have port din_ser  input  1  serial input bit for SHL/SHR.
REQ-010 SHALL have port q  output  WIDTH  register contents.
REQ-011 SHALL have port dout_msb  output  1  q[WIDTH-1].
REQ-012 SHALL have port dout_lsb  output  1  q[0].
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; DONE always returns to IDLE on the next edge.
REQ-016 SHALL latch mode and count when start=1 in IDLE; start outside IDLE is ignored and does not queue.
REQ-017 LOAD SHALL write din_par into q on the start edge and go to DONE.
REQ-018 HOLD, reserved opcode 7, or count=0 with any shift mode SHALL leave q unchanged and go to DONE.
REQ-019 Shift mode with count>0 SHALL go to RUN and perform exactly one step per RUN cycle, count steps total, then go to DONE.
REQ-020 SHL step: q <= {q[WIDTH-2:0], din_ser}; SHR step: q <= {din_ser, q[WIDTH-1:1]}.
REQ-021 ASR step: q <= {q[WIDTH-1], q[WIDTH-1:1]} (sign replicated).
REQ-022 ROL step: q <= {q[WIDTH-2:0], q[WIDTH-1]}; ROR step: q <= {q[0], q[WIDTH-1:1]}.
REQ-023 count > WIDTH SHALL be executed literally (no clamp); for ROL/ROR the result therefore equals a rotation by count mod WIDTH.
REQ-024 din_ser SHALL be sampled on each step edge, not latched at start.
REQ-025 Latency: start at edge t, last step at edge t+count, done high during the cycle after edge t+count (after edge t for LOAD/HOLD/count=0).
REQ-026 busy SHALL be high in RUN and DONE; a new start is accepted in the same cycle busy is low.
REQ-027 q SHALL not change in IDLE or DONE except by LOAD or reset.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force q=0, state=IDLE, busy=0, done=0, latched count=0, overriding any in-flight operation and any same-cycle start.
REQ-029 rst_n SHALL have no asynchronous effect.

Configuration
REQ-030 Macro USR_ROTATE_EN defined: ROL/ROR behave per REQ-022.
REQ-031 USR_ROTATE_EN undefined: opcodes 5 and 6 SHALL behave as HOLD (REQ-018); no rotate logic synthesised.

Structure
REQ-032 Package usr_pkg SHALL hold the mode enumeration (HOLD..ROR), the FSM state enumeration, and the reserved-opcode constant.
REQ-033 Storage SHALL be built from WIDTH instances of sub-module dff_sync (D, enable, clk, rst_n, Q; synchronous active-low reset); next-state mux and FSM live in universal_shift_reg.

Verification (WIDTH=8)
REQ-034 LOAD 0xA5 -> q=0xA5 after 1 edge, done pulses next cycle, busy high 1 cycle.
REQ-035 q=0x81, ASR count=3 -> q=0xF0 after 3 RUN cycles, done on 4th cycle; then SHR count=2 din_ser=0 -> q=0x3C.
REQ-036 q=0x01, SHL count=4 with din_ser sequence 1,0,1,1 -> q=0x1B; dout_msb=0, dout_lsb=1.
REQ-037 USR_ROTATE_EN defined: q=0x96, ROL count=11 -> q=0xB4; undefined: same stimulus -> q=0x96, done after 1 cycle.
REQ-038 count=0 SHL -> q unchanged, done one cycle after start; start pulsed during RUN -> ignored, no extra done.
REQ-039 rst_n=0 mid-RUN of SHL count=6 on q=0xFF -> next edge q=0x00, busy=0, done=0; no done pulse follows.
